data_matrix_regfile: RTL and testbench

DATA_MATRIX_REGFILE -- requirements
Module: data_matrix_regfile

---
 rtl/data_matrix_regfile_if.sv | 36 +++
 rtl/data_matrix_regfile.sv | 79 +++++++
 tb/tb_data_matrix_regfile.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/data_matrix_regfile_if.sv
// data_matrix_regfile_if
// Bundles the register-file datapath signals between the controller/datapath
// (master) and the register file (slave).
//   bus      16  shared datapath bus, written on ld_reg / ld_cc
//   ir       16  current instruction
//   drmux     2  destination select
//   sr1mux    2  first-operand select
//   ld_reg    1  register write enable
//   ld_cc     1  condition-code update enable
//   sr1/sr2  16  operand read ports
//   ir_slice  6  ir[5:0] for immediate decode
//   n, z, p   1  condition-code flags
interface data_matrix_regfile_if;
   logic [15:0] bus;
   logic [15:0] ir;
   logic [1:0]  drmux;
   logic [1:0]  sr1mux;
   logic        ld_reg;
   logic        ld_cc;
   logic [15:0] sr1;
   logic [15:0] sr2;
   logic [5:0]  ir_slice;
   logic        n;
   logic        z;
   logic        p;

   modport master (
      output bus, ir, drmux, sr1mux, ld_reg, ld_cc,
      input  sr1, sr2, ir_slice, n, z, p
   );

   modport slave (
      input  bus, ir, drmux, sr1mux, ld_reg, ld_cc,
      output sr1, sr2, ir_slice, n, z, p
   );
endinterface

// File: rtl/data_matrix_regfile.sv
// data_matrix_regfile
// Eight 16-bit general registers R0-R7 plus a one-hot NZP condition register.
// Reads are combinational; writes and NZP updates happen on the rising edge.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (R0-R7 -> 0, NZP -> 010)
//   rf   register-file interface (slave side)
module data_matrix_regfile (
   input logic                  clk,
   input logic                  rst,
   data_matrix_regfile_if.slave rf
);

   logic [15:0] regs [8];
   logic [2:0]  nzp;
   logic [2:0]  dest_sel;
   logic [2:0]  sr1_sel;
   logic [2:0]  nzp_next;

   // Only ir[11:0] participates in register selection and slicing.
   logic unused_ir;
   assign unused_ir = ^rf.ir[15:12];

   // Reserved drmux code 11 behaves as 00.
   always_comb begin
      dest_sel = rf.ir[11:9];
      case (rf.drmux)
         2'b01:   dest_sel = 3'd7;
         2'b10:   dest_sel = 3'd6;
         default: dest_sel = rf.ir[11:9];
      endcase
   end

   // Reserved sr1mux code 11 behaves as 01.
   always_comb begin
      sr1_sel = rf.ir[8:6];
      case (rf.sr1mux)
         2'b00:   sr1_sel = rf.ir[11:9];
         2'b10:   sr1_sel = 3'd6;
         default: sr1_sel = rf.ir[8:6];
      endcase
   end

   // Flags derive from the bus sample itself, so a combined register write
   // and CC update reflect the value being written.
   always_comb begin
      nzp_next = 3'b001;
      if (rf.bus[15]) begin
         nzp_next = 3'b100;
      end else if (rf.bus == 16'h0000) begin
         nzp_next = 3'b010;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= 16'h0000;
         end
         nzp <= 3'b010;
      end else begin
         if (rf.ld_reg) begin
            regs[dest_sel] <= rf.bus;
         end
         if (rf.ld_cc) begin
            nzp <= nzp_next;
         end
      end
   end

   // No write bypass: reads in a write cycle return the pre-write contents.
   assign rf.sr1      = regs[sr1_sel];
   assign rf.sr2      = regs[rf.ir[2:0]];
   assign rf.ir_slice = rf.ir[5:0];
   assign rf.n        = nzp[2];
   assign rf.z        = nzp[1];
   assign rf.p        = nzp[0];

endmodule

// File: tb/tb_data_matrix_regfile.sv
module tb_data_matrix_regfile;

   typedef struct {
      string       tag;
      logic [15:0] sr1;
      logic [15:0] sr2;
      logic [2:0]  nzp;
      logic [5:0]  slice;
   } exp_t;

   logic clk;
   logic rst;
   logic chk;
   logic stim_done;
   exp_t exp_q[$];
   int   total;
   int   bad;

   data_matrix_regfile_if rf_if();

   data_matrix_regfile dut (
      .clk (clk),
      .rst (rst),
      .rf  (rf_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mk_ir(input logic [2:0] dr, input logic [2:0] s1,
                                         input logic [2:0] hi, input logic [2:0] s2);
      return {4'b0000, dr, s1, hi, s2};
   endfunction

   // Drive one cycle of inputs; when do_chk is set, the expected read-port
   // values for this cycle (before its edge) are queued for the monitor.
   task automatic cycle(input string tag, input logic r, input logic [15:0] ir,
                        input logic [1:0] drm, input logic [1:0] s1m,
                        input logic ldr, input logic ldc, input logic [15:0] bus,
                        input logic do_chk, input logic [15:0] e_sr1,
                        input logic [15:0] e_sr2, input logic [2:0] e_nzp);
      exp_t e;
      rst           = r;
      rf_if.ir      = ir;
      rf_if.drmux   = drm;
      rf_if.sr1mux  = s1m;
      rf_if.ld_reg  = ldr;
      rf_if.ld_cc   = ldc;
      rf_if.bus     = bus;
      if (do_chk) begin
         e.tag   = tag;
         e.sr1   = e_sr1;
         e.sr2   = e_sr2;
         e.nzp   = e_nzp;
         e.slice = ir[5:0];
         exp_q.push_back(e);
      end
      chk = do_chk;
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string tag, input string what, input logic [15:0] act,
                      input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s.%s actual=%h required=%h", tag, what, act, req);
      end
   endtask

   // Monitor: pops one expectation per strobed cycle and compares at negedge.
   initial begin
      exp_t e;
      total = 0;
      bad   = 0;
      @(negedge clk);
      while (!stim_done) begin
         if (chk) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard_underflow actual=empty required=entry");
            end else begin
               e = exp_q.pop_front();
               cmp(e.tag, "sr1", rf_if.sr1, e.sr1);
               cmp(e.tag, "sr2", rf_if.sr2, e.sr2);
               cmp(e.tag, "nzp", {13'd0, rf_if.n, rf_if.z, rf_if.p}, {13'd0, e.nzp});
               cmp(e.tag, "ir_slice", {10'd0, rf_if.ir_slice}, {10'd0, e.slice});
            end
         end
         @(negedge clk);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_done = 1'b0;
      chk       = 1'b0;
      rst       = 1'b1;
      rf_if.ir = '0; rf_if.drmux = '0; rf_if.sr1mux = '0;
      rf_if.ld_reg = 1'b0; rf_if.ld_cc = 1'b0; rf_if.bus = '0;
      @(posedge clk);
      #1;

      // Reset with a competing load of FFFF.
      cycle("rst_load", 1, mk_ir(3'd1, 0, 0, 0), 2'b00, 2'b01, 1, 1, 16'hFFFF, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         cycle($sformatf("rst_r%0d", k), 0, mk_ir(0, 3'(k), 3'(k), 3'(k)), 2'b00, 2'b01,
               0, 0, 16'hFFFF, 1, 16'h0000, 16'h0000, 3'b010);
      end

      // Write R3 = 1234, read back on both ports.
      cycle("wr_r3", 0, mk_ir(3'd3, 0, 0, 0), 2'b00, 2'b01, 1, 0, 16'h1234, 0, 0, 0, 0);
      cycle("rd_r3", 0, mk_ir(0, 3'd3, 3'd5, 3'd3), 2'b00, 2'b01, 0, 0, 16'h0, 1,
            16'h1234, 16'h1234, 3'b010);

      // Read-during-write on R5.
      cycle("wr_r5a", 0, mk_ir(3'd5, 0, 0, 0), 2'b00, 2'b01, 1, 0, 16'h00AA, 0, 0, 0, 0);
      cycle("rdw_pre", 0, mk_ir(3'd5, 3'd5, 0, 3'd5), 2'b00, 2'b00, 1, 0, 16'h5555, 1,
            16'h00AA, 16'h00AA, 3'b010);
      cycle("rdw_post", 0, mk_ir(3'd5, 3'd5, 0, 3'd5), 2'b00, 2'b00, 0, 0, 16'h0, 1,
            16'h5555, 16'h5555, 3'b010);

      // Condition codes; reads of R5/R3 confirm registers untouched.
      cycle("cc_8000", 0, mk_ir(0, 3'd5, 0, 3'd3), 2'b00, 2'b01, 0, 1, 16'h8000, 0, 0, 0, 0);
      cycle("cc_n", 0, mk_ir(0, 3'd5, 0, 3'd3), 2'b00, 2'b01, 0, 1, 16'h0000, 1,
            16'h5555, 16'h1234, 3'b100);
      cycle("cc_z", 0, mk_ir(0, 3'd5, 0, 3'd3), 2'b00, 2'b01, 0, 1, 16'h7FFF, 1,
            16'h5555, 16'h1234, 3'b010);
      cycle("cc_p", 0, mk_ir(0, 3'd5, 0, 3'd3), 2'b00, 2'b01, 0, 0, 16'h8000, 1,
            16'h5555, 16'h1234, 3'b001);
      cycle("cc_hold", 0, mk_ir(0, 3'd5, 0, 3'd3), 2'b00, 2'b01, 0, 0, 16'hxxxx, 1,
            16'h5555, 16'h1234, 3'b001);
      cycle("cc_hold_x", 0, mk_ir(0, 3'd5, 0, 3'd3), 2'b00, 2'b01, 0, 0, 16'h0, 1,
            16'h5555, 16'h1234, 3'b001);

      // Alternate destinations R7 / R6 and sr1mux=10.
      cycle("wr_r7", 0, mk_ir(3'd1, 0, 0, 0), 2'b01, 2'b01, 1, 0, 16'h3000, 0, 0, 0, 0);
      cycle("wr_r6", 0, mk_ir(3'd1, 0, 0, 0), 2'b10, 2'b01, 1, 0, 16'hFE00, 0, 0, 0, 0);
      cycle("rd_r6_r7", 0, mk_ir(3'd1, 3'd1, 3'd2, 3'd7), 2'b00, 2'b10, 0, 0, 16'h0, 1,
            16'hFE00, 16'h3000, 3'b001);
      cycle("rd_r1_r6", 0, mk_ir(3'd1, 3'd1, 0, 3'd6), 2'b00, 2'b00, 0, 0, 16'h0, 1,
            16'h0000, 16'hFE00, 3'b001);

      // Reserved drmux=11 targets ir[11:9]=R2, combined with CC update.
      cycle("wr_r2", 0, mk_ir(3'd2, 0, 0, 0), 2'b11, 2'b01, 1, 1, 16'h8BEE, 0, 0, 0, 0);
      cycle("rd_r2", 0, mk_ir(3'd2, 3'd4, 0, 3'd0), 2'b00, 2'b00, 0, 0, 16'h0, 1,
            16'h8BEE, 16'h0000, 3'b100);
      cycle("sr1mux_11", 0, mk_ir(3'd5, 3'd2, 3'd7, 3'd7), 2'b00, 2'b11, 0, 0, 16'h0, 1,
            16'h8BEE, 16'h3000, 3'b100);

      // Combined write/CC with zero: NZP follows the written value.
      cycle("wr_r4_zero", 0, mk_ir(3'd4, 0, 0, 0), 2'b00, 2'b01, 1, 1, 16'h0000, 0, 0, 0, 0);
      cycle("wr_r4_pos", 0, mk_ir(3'd4, 0, 0, 0), 2'b00, 2'b01, 1, 0, 16'h0042, 1,
            16'h0000, 16'h0000, 3'b010);

      // Reset mid-operation discards a concurrent write and CC update.
      cycle("rst_mid", 1, mk_ir(3'd4, 3'd4, 0, 3'd4), 2'b00, 2'b01, 1, 1, 16'h8001, 1,
            16'h0042, 16'h0042, 3'b010);
      cycle("post_rst", 0, mk_ir(3'd4, 3'd4, 3'd6, 3'd2), 2'b00, 2'b01, 0, 0, 16'h0, 1,
            16'h0000, 16'h0000, 3'b010);
      cycle("post_rst_r7", 0, mk_ir(0, 3'd7, 3'd1, 3'd6), 2'b00, 2'b01, 0, 0, 16'h0, 1,
            16'h0000, 16'h0000, 3'b010);

      cycle("idle", 0, 16'h0, 2'b00, 2'b01, 0, 0, 16'h0, 0, 0, 0, 0);
      stim_done = 1'b1;
   end

endmodule
